// File: rtl/fp_divider.sv
// Iterative fp32 divider: restoring mantissa division, one quotient bit per clock.
// Truncating rounding, subnormals flushed to zero, specials resolved before the divide loop.
module fp_divider #(
    parameter int          QBITS     = 25,
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        En,
    output logic [31:0] Result,
    output logic        Ready,
    output logic        NaN
);

    localparam int CW = 5;

    typedef enum logic [2:0] {IDLE, UNPACK, DIVIDE, NORM, DONE} state_t;
    typedef enum logic [1:0] {CL_ZERO, CL_FINITE, CL_INF, CL_NAN} class_t;

    state_t                   state_q, state_d;
    logic [31:0]              a_q, a_d, b_q, b_d;
    logic                     sign_q, sign_d;
    logic signed [9:0]        exp_q, exp_d;
    logic [23:0]              mb_q, mb_d;
    logic [24:0]              rem_q, rem_d;
    logic [QBITS-2:0]         quo_q, quo_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [31:0]              result_q, result_d;
    logic                     ready_q, ready_d;
    logic                     nan_q, nan_d;

    class_t                   cls_a, cls_b;
    logic                     sgn, ge;
    logic [24:0]              rem_sub;
    logic [QBITS-1:0]         q_full;
    logic [22:0]              frac;
    logic signed [9:0]        e_adj;

    function automatic class_t classify(input logic [31:0] x);
        if (x[30:23] == 8'd0)
            return CL_ZERO;
        else if (x[30:23] == 8'hFF)
            return (x[22:0] == 23'd0) ? CL_INF : CL_NAN;
        else
            return CL_FINITE;
    endfunction

    // Exponent saturation: underflow flushes to signed zero, overflow to signed infinity.
    function automatic logic [31:0] saturate_pack(input logic s, input logic signed [9:0] e,
                                                  input logic [22:0] f);
        if (e <= 10'sd0)
            return {s, 31'd0};
        else if (e >= 10'sd255)
            return {s, 8'hFF, 23'd0};
        else
            return {s, e[7:0], f};
    endfunction

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mb_d     = mb_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        nan_d    = nan_q;
        ready_d  = 1'b0;
        frac     = 23'd0;
        e_adj    = exp_q;

        cls_a   = classify(a_q);
        cls_b   = classify(b_q);
        sgn     = a_q[31] ^ b_q[31];
        ge      = (rem_q >= {1'b0, mb_q});
        rem_sub = ge ? (rem_q - {1'b0, mb_q}) : rem_q;
        q_full  = {quo_q, ge};

        unique case (state_q)
            IDLE: begin
                if (En) begin
                    a_d     = A;
                    b_d     = B;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                sign_d  = sgn;
                state_d = DONE;
                if (cls_a == CL_NAN || cls_b == CL_NAN ||
                    (cls_a == CL_ZERO && cls_b == CL_ZERO) ||
                    (cls_a == CL_INF && cls_b == CL_INF)) begin
                    result_d = CANON_NAN;
                    nan_d    = 1'b1;
                end else if (cls_a == CL_INF || cls_b == CL_ZERO) begin
                    result_d = {sgn, 8'hFF, 23'd0};
                    nan_d    = 1'b0;
                end else if (cls_a == CL_ZERO || cls_b == CL_INF) begin
                    result_d = {sgn, 31'd0};
                    nan_d    = 1'b0;
                end else begin
                    exp_d   = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'sd127;
                    mb_d    = {1'b1, b_q[22:0]};
                    rem_d   = {2'b01, a_q[22:0]};
                    quo_d   = '0;
                    cnt_d   = '0;
                    state_d = DIVIDE;
                end
            end
            DIVIDE: begin
                // The last quotient bit is resolved inside NORM, so the loop runs QBITS-1 times.
                rem_d = rem_sub << 1;
                quo_d = q_full[QBITS-2:0];
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(QBITS - 2))
                    state_d = NORM;
            end
            NORM: begin
                if (q_full[QBITS-1]) begin
                    frac  = q_full[QBITS-2:1];
                    e_adj = exp_q;
                end else begin
                    frac  = q_full[QBITS-3:0];
                    e_adj = exp_q - 10'sd1;
                end
                result_d = saturate_pack(sign_q, e_adj, frac);
                nan_d    = 1'b0;
                state_d  = DONE;
            end
            DONE: begin
                ready_d = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            result_q <= 32'd0;
            ready_q  <= 1'b0;
            nan_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            ready_q  <= ready_d;
            nan_q    <= nan_d;
            cnt_q    <= cnt_d;
        end
        a_q    <= a_d;
        b_q    <= b_d;
        sign_q <= sign_d;
        exp_q  <= exp_d;
        mb_q   <= mb_d;
        rem_q  <= rem_d;
        quo_q  <= quo_d;
    end

    assign Result = result_q;
    assign Ready  = ready_q;
    assign NaN    = nan_q;

endmodule

// File: tb/tb_fp_divider.sv
// Bench for fp_divider: directed literal cases plus randomized operands checked
// against an integer-arithmetic model of truncating fp32 division.
module tb_fp_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        En;
    logic [31:0] A, B;
    logic [31:0] Result;
    logic        Ready, NaN;

    fp_divider dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .En(En),
        .Result(Result), .Ready(Ready), .NaN(NaN)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic        nan;
        int          lat;
        int          start;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    function automatic bit is_special(input logic [31:0] a, input logic [31:0] b);
        return (a[30:23] == 8'd0) || (a[30:23] == 8'hFF) || (b[30:23] == 8'd0) || (b[30:23] == 8'hFF);
    endfunction

    // Returns {nan, result}.
    function automatic logic [32:0] model_div(input logic [31:0] a, input logic [31:0] b);
        int     ea, eb, e;
        bit     s, az, bz, ai, bi, an, bn;
        longint ma, mb, q, f;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        s  = a[31] ^ b[31];
        az = (ea == 0);
        bz = (eb == 0);
        ai = (ea == 255) && (a[22:0] == 23'd0);
        bi = (eb == 255) && (b[22:0] == 23'd0);
        an = (ea == 255) && (a[22:0] != 23'd0);
        bn = (eb == 255) && (b[22:0] != 23'd0);
        if (an || bn || (az && bz) || (ai && bi)) return {1'b1, 32'h7FC00000};
        if (ai || bz) return {1'b0, s, 8'hFF, 23'd0};
        if (az || bi) return {1'b0, s, 31'd0};
        ma = longint'(a[22:0]) + (64'sd1 << 23);
        mb = longint'(b[22:0]) + (64'sd1 << 23);
        q  = (ma << 24) / mb;
        e  = ea - eb + 127;
        if (q >= (64'sd1 << 24)) begin
            f = (q >> 1) & 64'h7FFFFF;
        end else begin
            f = q & 64'h7FFFFF;
            e = e - 1;
        end
        if (e <= 0) return {1'b0, s, 31'd0};
        if (e >= 255) return {1'b0, s, 8'hFF, 23'd0};
        return {1'b0, s, 8'(e), 23'(f)};
    endfunction

    // Compare process: every Ready cycle is matched against the oldest expected result.
    exp_t mon_e;
    logic prev_ready = 1'b0;
    always @(negedge clk) begin
        if (Ready) begin
            if (prev_ready) check("ready_pulse_width", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ready: got Ready=1 Result=%h expected no Ready", Result);
            end else begin
                mon_e = exp_q.pop_front();
                check("result", Result, mon_e.res);
                check("nan", {31'd0, NaN}, {31'd0, mon_e.nan});
                check("latency", 32'(cyc - mon_e.start), 32'(mon_e.lat));
            end
        end
        prev_ready = Ready;
    end

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input bit push,
                            input logic [31:0] res, input logic nan);
        exp_t e;
        @(negedge clk);
        A  = a;
        B  = b;
        En = 1'b1;
        if (push) begin
            e.res   = res;
            e.nan   = nan;
            e.lat   = is_special(a, b) ? 2 : 27;
            e.start = cyc + 1;
            exp_q.push_back(e);
        end
        @(negedge clk);
        En = 1'b0;
        A  = $urandom;
        B  = $urandom;
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got no Ready in %0d cycles expected one", n);
            exp_q.delete();
        end
    endtask

    task automatic directed(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] res, input logic nan);
        logic [32:0] m;
        m = model_div(a, b);
        check("model_pin", m[31:0], res);
        start_op(a, b, 1'b1, res, nan);
        wait_done();
    endtask

    logic [31:0] dir_a [12] = '{32'h40C00000, 32'h3F800000, 32'h40700000, 32'h7FC00000,
                                32'h00000000, 32'h40A00000, 32'h00000000, 32'h3FC00000,
                                32'h7F7FFFFF, 32'h00800000, 32'h00400000, 32'hFF800000};
    logic [31:0] dir_b [12] = '{32'h40000000, 32'h40400000, 32'hBFC00000, 32'h40000000,
                                32'h00000000, 32'h00000000, 32'hC0A00000, 32'hFF800000,
                                32'h3F000000, 32'h40000000, 32'h3F800000, 32'h7F800000};
    logic [31:0] dir_r [12] = '{32'h40400000, 32'h3EAAAAAA, 32'hC0200000, 32'h7FC00000,
                                32'h7FC00000, 32'h7F800000, 32'h80000000, 32'h80000000,
                                32'h7F800000, 32'h00000000, 32'h00000000, 32'h7FC00000};
    logic        dir_n [12] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
                                1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        #800000;
        $display("FAIL watchdog: got no finish expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] ra, rb;
        logic [32:0] m;
        reset = 1'b1;
        En    = 1'b0;
        A     = 32'd0;
        B     = 32'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_result", Result, 32'd0);
        check("reset_nan", {31'd0, NaN}, 32'd0);
        check("reset_ready", {31'd0, Ready}, 32'd0);

        for (int i = 0; i < 12; i++) directed(dir_a[i], dir_b[i], dir_r[i], dir_n[i]);

        // Busy rejection: a second En mid-operation must be ignored.
        start_op(32'h40C00000, 32'h40000000, 1'b1, 32'h40400000, 1'b0);
        repeat (9) @(negedge clk);
        A  = 32'h3F800000;
        B  = 32'h40400000;
        En = 1'b1;
        @(negedge clk);
        En = 1'b0;
        wait_done();
        repeat (30) @(negedge clk);
        directed(32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 1'b0);

        // Reset in the middle of a divide aborts it and clears the outputs.
        directed(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);
        start_op(32'h40C00000, 32'h40000000, 1'b0, 32'd0, 1'b0);
        repeat (11) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_result", Result, 32'd0);
        check("abort_nan", {31'd0, NaN}, 32'd0);
        repeat (30) @(negedge clk);
        directed(32'h40C00000, 32'h40000000, 32'h40400000, 1'b0);

        // Randomized operands, biased toward specials and exponent limits.
        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
                1: rb[30:23] = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00;
                2: begin
                    ra[30:23] = 8'($urandom_range(200, 254));
                    rb[30:23] = 8'($urandom_range(1, 80));
                end
                3: begin
                    ra[30:23] = 8'($urandom_range(1, 60));
                    rb[30:23] = 8'($urandom_range(150, 254));
                end
                4: rb[30:23] = ra[30:23];
                5: begin
                    ra[30:23] = 8'($urandom_range(100, 150));
                    rb[30:23] = 8'($urandom_range(100, 150));
                end
                default: ;
            endcase
            m = model_div(ra, rb);
            start_op(ra, rb, 1'b1, m[31:0], m[32]);
            wait_done();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
